// File: rtl/pp_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: stage index enum, default stage count and counter width,
//           and a width helper for down-counters.
package pp_pkg;

  // Stage indices of the classic five-stage in-order pipeline.
  typedef enum logic [2:0] {
    PP_IF  = 3'd0,
    PP_DEC = 3'd1,
    PP_EX  = 3'd2,
    PP_MEM = 3'd3,
    PP_WB  = 3'd4
  } pp_stage_e;

  localparam int PP_NSTAGE = 5;
  localparam int PP_CNT_W  = 16;

  // Bits needed to hold the values 0..n, never less than one bit.
  function automatic int pp_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pp_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the rising clk edge after inc/clr.
// Backpressure: none; clr wins over inc, the count sticks at all-ones.
// Ports: clk, rst_n (async, active-low), inc, clr, cnt[CNT_W-1:0].
import pp_pkg::*;

module pp_sat_cnt #(
  parameter int CNT_W = PP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pp_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush from stage requests.
// Latency: stall_o/bubble_o/flush_o are combinational (zero cycles); pending
//          flushes, init window and counters update on the rising clk edge.
// Backpressure: a flush from a stalled requester is held pending until that
//          stage advances; repeated requests while pending merge into one.
// Ports: clk, rst_n (async, active-low); stall_req_i/flush_req_i per stage;
//        perf_clr_i; stall_o, bubble_o, flush_o per stage; init_o;
//        stall_cnt_o, flush_cnt_o.
// Optional feature: define PP_HAZARD_PERF_EN to build the saturating
//        performance counters; otherwise the counter outputs read 0.
import pp_pkg::*;

module pp_hazard_ctrl #(
  parameter int NSTAGE   = PP_NSTAGE,
  parameter int INIT_CYC = 1,
  parameter int CNT_W    = PP_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stall_req_i,
  input  logic [NSTAGE-1:0] flush_req_i,
  input  logic              perf_clr_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] bubble_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              init_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int INIT_W = pp_cnt_w(INIT_CYC);

  logic [NSTAGE-1:0] raw_stall;
  logic [NSTAGE-1:0] flush_req_g;
  logic [NSTAGE-1:0] eff_flush;
  logic [NSTAGE-1:0] pend_r;
  logic [INIT_W-1:0] init_cnt_r;

  // A stall at stage k freezes every stage upstream of it.
  always_comb begin
    raw_stall = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (k >= i) raw_stall[i] = raw_stall[i] | stall_req_i[k];
      end
    end
  end

  // Requests are ignored while in reset so nothing leaks out before release.
  assign flush_req_g = flush_req_i & {NSTAGE{rst_n}};
  assign eff_flush   = (flush_req_g | pend_r) & ~raw_stall;

  // eff_flush and raw_stall are exclusive per bit, so keeping only the
  // stalled bits both sets new pending flushes and retires issued ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_r <= '0;
    else        pend_r <= (pend_r | flush_req_g) & raw_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_cnt_r <= INIT_W'(INIT_CYC);
    else if (init_cnt_r != '0) init_cnt_r <= init_cnt_r - INIT_W'(1);
  end

  assign init_o = (init_cnt_r != '0);

  // A flush from stage j squashes everything younger (upstream) than j.
  always_comb begin
    flush_o = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      for (int j = 0; j < NSTAGE; j++) begin
        if (j > i) flush_o[i] = flush_o[i] | eff_flush[j];
      end
    end
  end

  // Flush overrides stall; the rst_n term keeps stalls quiet in reset even
  // when there is no init window.
  assign stall_o = raw_stall & ~flush_o & {NSTAGE{~init_o & rst_n}};

  // Bubble where a stalled stage hands off to a stage that keeps moving.
  always_comb begin
    bubble_o = '0;
    for (int i = 0; i < NSTAGE - 1; i++) begin
      bubble_o[i] = stall_o[i] & ~stall_o[i+1];
    end
  end

`ifdef PP_HAZARD_PERF_EN
  pp_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_o[0]),
    .clr   (perf_clr_i),
    .cnt   (stall_cnt_o)
  );

  pp_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|flush_o),
    .clr   (perf_clr_i),
    .cnt   (flush_cnt_o)
  );
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign stall_cnt_o     = '0;
  assign flush_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_pp_hazard_ctrl.sv
// Directed bench for pp_hazard_ctrl with NSTAGE=5, INIT_CYC=2, CNT_W=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
import pp_pkg::*;

module tb_pp_hazard_ctrl;

  localparam int NS = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] stall_req_i;
  logic [NS-1:0] flush_req_i;
  logic          perf_clr_i;
  logic [NS-1:0] stall_o;
  logic [NS-1:0] bubble_o;
  logic [NS-1:0] flush_o;
  logic          init_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  pp_hazard_ctrl #(.NSTAGE(NS), .INIT_CYC(2), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_req_i (stall_req_i),
    .flush_req_i (flush_req_i),
    .perf_clr_i  (perf_clr_i),
    .stall_o     (stall_o),
    .bubble_o    (bubble_o),
    .flush_o     (flush_o),
    .init_o      (init_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef PP_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [NS-1:0] s,
                         input logic [NS-1:0] b, input logic [NS-1:0] f);
    #1;
    chk({tag, ".stall"},  32'(stall_o),  32'(s));
    chk({tag, ".bubble"}, 32'(bubble_o), 32'(b));
    chk({tag, ".flush"},  32'(flush_o),  32'(f));
  endtask

  logic [NS-1:0] b_ex;

  initial begin
    b_ex = '0;
    b_ex[PP_EX] = 1'b1;

    rst_n = 1'b0; stall_req_i = 5'b00010; flush_req_i = 5'b00100; perf_clr_i = 1'b0;
    // In reset: flush request gated, stalls suppressed, init active.
    #12;
    chk("rst.init", 32'(init_o), 32'd1);
    chk_out("rst", 5'b00000, 5'b00000, 5'b00000);
    chk("rst.scnt", 32'(stall_cnt_o), 32'd0);
    chk("rst.fcnt", 32'(flush_cnt_o), 32'd0);

    // Release with a decode stall held: two init cycles, then stall applies.
    step(); rst_n = 1'b1; flush_req_i = '0;
    #1; chk("init0", 32'(init_o), 32'd1);
    chk_out("init0", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk("init1", 32'(init_o), 32'd1);
    chk_out("init1", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk("init2", 32'(init_o), 32'd0);
    chk_out("dec_stall", 5'b00011, 5'b00010, 5'b00000);
    chk("scnt0", 32'(stall_cnt_o), 32'd0);

    // Five stalled cycles: 2-bit counter saturates at 3.
    for (int c = 0; c < 5; c++) step();
    chk("scnt_sat", 32'(stall_cnt_o), PERF ? 32'd3 : 32'd0);
    perf_clr_i = 1'b1;
    step();
    chk("scnt_clr", 32'(stall_cnt_o), 32'd0);
    chk("fcnt_clr", 32'(flush_cnt_o), 32'd0);
    perf_clr_i = 1'b0;

    // Memory busy stalls everything upstream.
    stall_req_i = 5'b01000;
    chk_out("mem_stall", 5'b01111, 5'b01000, 5'b00000);

    // Execute flush over a decode stall: flush wins.
    step();
    stall_req_i = 5'b00010; flush_req_i = b_ex;
    chk_out("ex_flush", 5'b00000, 5'b00000, 5'b00011);
    step();
    flush_req_i = '0; stall_req_i = '0;
    chk("fcnt1", 32'(flush_cnt_o), PERF ? 32'd1 : 32'd0);
    chk_out("idle", 5'b00000, 5'b00000, 5'b00000);

    // One-cycle flush pulse under a 3-cycle mem stall goes pending.
    stall_req_i = 5'b01000; flush_req_i = 5'b00100;
    chk_out("pend_c1", 5'b01111, 5'b01000, 5'b00000);
    step(); flush_req_i = '0;
    chk_out("pend_c2", 5'b01111, 5'b01000, 5'b00000);
    step();
    chk_out("pend_c3", 5'b01111, 5'b01000, 5'b00000);
    step(); stall_req_i = '0;
    chk_out("pend_issue", 5'b00000, 5'b00000, 5'b00011);
    step();
    chk_out("pend_done", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_out("pend_done2", 5'b00000, 5'b00000, 5'b00000);

    // Same-stage stall and flush: stall applies, flush goes pending; then reset.
    stall_req_i = 5'b00100; flush_req_i = 5'b00100;
    chk_out("same_stage", 5'b00111, 5'b00100, 5'b00000);
    step(); flush_req_i = '0;
    rst_n = 1'b0;
    #1;
    chk("rst2.init", 32'(init_o), 32'd1);
    chk_out("rst2", 5'b00000, 5'b00000, 5'b00000);
    chk("rst2.fcnt", 32'(flush_cnt_o), 32'd0);
    step(); stall_req_i = '0; rst_n = 1'b1;
    chk_out("rel2_a", 5'b00000, 5'b00000, 5'b00000);
    chk("rel2_a.init", 32'(init_o), 32'd1);
    step();
    chk_out("rel2_b", 5'b00000, 5'b00000, 5'b00000);
    chk("rel2_b.init", 32'(init_o), 32'd1);
    step();
    chk_out("rel2_c", 5'b00000, 5'b00000, 5'b00000);
    chk("rel2_c.init", 32'(init_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
